// File: rtl/fir_stim_gen_if.sv
// -----------------------------------------------------------------------------
// fir_stim_gen_if
//
// Purpose:
//   Bundles the control inputs, the coefficient bus and the sample stream of
//   the FIR stimulus generator. The generator connects through the master
//   modport. The consumer or test harness connects through the slave modport.
//
// Signals (direction as seen from the master / generator):
//   START    in   1   start a run, honoured only while idle
//   GAP_EN   in   1   enable periodic VOUT gaps
//   HOLD     in   1   stall, no sample emitted while high
//   H_WE     in   1   coefficient write strobe, honoured only while idle
//   H_ADDR   in   4   coefficient index 0..8, larger values ignored
//   H_DATA   in   NB  coefficient value, signed
//   H0..H8   out  NB  coefficient registers, signed
//   DOUT     out  NB  sample, signed two's complement
//   VOUT     out  1   DOUT valid
//   END_SIM  out  1   run complete, held high until reset
// -----------------------------------------------------------------------------
interface fir_stim_gen_if #(
    parameter int NB = 11
);
    logic                 START;
    logic                 GAP_EN;
    logic                 HOLD;
    logic                 H_WE;
    logic [3:0]           H_ADDR;
    logic signed [NB-1:0] H_DATA;

    logic signed [NB-1:0] H0;
    logic signed [NB-1:0] H1;
    logic signed [NB-1:0] H2;
    logic signed [NB-1:0] H3;
    logic signed [NB-1:0] H4;
    logic signed [NB-1:0] H5;
    logic signed [NB-1:0] H6;
    logic signed [NB-1:0] H7;
    logic signed [NB-1:0] H8;

    logic signed [NB-1:0] DOUT;
    logic                 VOUT;
    logic                 END_SIM;

    // Generator side: consumes control, drives coefficients and the stream.
    modport master (
        input  START, GAP_EN, HOLD, H_WE, H_ADDR, H_DATA,
        output H0, H1, H2, H3, H4, H5, H6, H7, H8,
        output DOUT, VOUT, END_SIM
    );

    // Consumer side: drives control, observes coefficients and the stream.
    modport slave (
        output START, GAP_EN, HOLD, H_WE, H_ADDR, H_DATA,
        input  H0, H1, H2, H3, H4, H5, H6, H7, H8,
        input  DOUT, VOUT, END_SIM
    );
endinterface

// File: rtl/fir_stim_gen.sv
// -----------------------------------------------------------------------------
// fir_stim_gen
//
// Purpose:
//   Stimulus transmitter for the FIR filters. It emits a pseudo-random signed
//   sample stream (DOUT/VOUT) taken from an 11-bit maximal-length LFSR. It also
//   holds the nine filter coefficients H0..H8, which are written while idle.
//   Periodic gaps (GAP_EN) and external stalls (HOLD) can thin the stream.
//   After the last sample the block drains for DRAIN_CYCLES cycles. It then
//   raises END_SIM and stays done until reset. The block can serve as an
//   on-chip BIST source or replace the file-driven generator in a bench.
//
// Ports:
//   CLK    in   clock, all logic on the rising edge
//   RST_n  in   synchronous reset, active low
//   bus    master modport of fir_stim_gen_if:
//            START, GAP_EN, HOLD, H_WE, H_ADDR, H_DATA  (inputs)
//            H0..H8, DOUT, VOUT, END_SIM                 (registered outputs)
//
// Parameters:
//   NB            sample and coefficient width
//   N_SAMPLES     valid samples per run (1..65535)
//   SEED          LFSR start value, a zero seed is replaced by 11'h001
//   GAP_PERIOD    gap period in RUN cycles (>= 2)
//   DRAIN_CYCLES  idle cycles between the last sample and END_SIM (>= 1)
// -----------------------------------------------------------------------------
module fir_stim_gen #(
    parameter int          NB           = 11,
    parameter int          N_SAMPLES    = 64,
    parameter logic [10:0] SEED         = 11'h001,
    parameter int          GAP_PERIOD   = 4,
    parameter int          DRAIN_CYCLES = 10
) (
    input  logic           CLK,
    input  logic           RST_n,
    fir_stim_gen_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [10:0] SEED_EFF    = (SEED == 11'd0) ? 11'h001 : SEED;
    localparam int          GW          = $clog2(GAP_PERIOD);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_PERIOD - 1);
    localparam logic [15:0] LAST_SAMPLE = 16'(N_SAMPLES - 1);
    localparam logic [15:0] LAST_DRAIN  = 16'(DRAIN_CYCLES - 1);

    state_t               r_state;
    logic [10:0]          r_lfsr;
    logic [15:0]          r_cnt;
    logic [GW-1:0]        r_gcnt;
    logic [15:0]          r_dcnt;
    logic signed [NB-1:0] r_dout;
    logic                 r_vout;
    logic                 r_end;
    logic signed [NB-1:0] r_h [0:8];

    logic [10:0]          w_lfsr_next;
    logic                 w_gap;
    logic                 w_stall;
    logic signed [NB-1:0] w_sample;

    // Fibonacci LFSR for x^11 + x^9 + 1. The feedback taps are bits 10 and 8.
    // The sequence has the maximal length 2047 and never reaches zero.
    assign w_lfsr_next = {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};

    // The last slot of every gap period is a gap when gaps are enabled.
    // HOLD stalls independently of the gap counter.
    assign w_gap    = bus.GAP_EN && (r_gcnt == GAP_LAST);
    assign w_stall  = bus.HOLD || w_gap;

    // The LFSR word is a signed 11-bit sample. It is sign-extended to NB.
    assign w_sample = NB'($signed(r_lfsr));

    // Main state machine. It updates all registered outputs, the coefficient
    // file and the run bookkeeping counters. In RUN the gap counter advances
    // on every cycle, including stalls. This keeps the gap pattern locked to
    // RUN time and independent of HOLD. The edge that emits the final sample
    // also moves the FSM to DRAIN. The VOUT of that sample is still visible
    // during the first DRAIN cycle. DRAIN therefore counts DRAIN_CYCLES edges
    // from that point, and END_SIM rises exactly DRAIN_CYCLES cycles after
    // the last valid cycle.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_lfsr  <= SEED_EFF;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_dcnt  <= '0;
            r_dout  <= '0;
            r_vout  <= 1'b0;
            r_end   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_h[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_vout <= 1'b0;
                    // Addresses above 8 match no register and are dropped.
                    if (bus.H_WE) begin
                        for (int i = 0; i < 9; i++) begin
                            if (bus.H_ADDR == 4'(i)) begin
                                r_h[i] <= bus.H_DATA;
                            end
                        end
                    end
                    if (bus.START) begin
                        r_state <= RUN;
                        r_gcnt  <= '0;
                        r_cnt   <= '0;
                        r_lfsr  <= SEED_EFF;
                    end
                end

                RUN: begin
                    r_gcnt <= (r_gcnt == GAP_LAST) ? '0 : r_gcnt + GW'(1);
                    if (w_stall) begin
                        r_vout <= 1'b0;
                    end else begin
                        r_dout <= w_sample;
                        r_vout <= 1'b1;
                        r_lfsr <= w_lfsr_next;
                        r_cnt  <= r_cnt + 16'd1;
                        if (r_cnt == LAST_SAMPLE) begin
                            r_state <= DRAIN;
                            r_dcnt  <= '0;
                        end
                    end
                end

                DRAIN: begin
                    r_vout <= 1'b0;
                    if (r_dcnt == LAST_DRAIN) begin
                        r_state <= DONE;
                        r_end   <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 16'd1;
                    end
                end

                DONE: begin
                    r_vout <= 1'b0;
                    r_end  <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                    r_vout  <= 1'b0;
                end
            endcase
        end
    end

    // Every output comes directly from a register.
    assign bus.DOUT    = r_dout;
    assign bus.VOUT    = r_vout;
    assign bus.END_SIM = r_end;
    assign bus.H0      = r_h[0];
    assign bus.H1      = r_h[1];
    assign bus.H2      = r_h[2];
    assign bus.H3      = r_h[3];
    assign bus.H4      = r_h[4];
    assign bus.H5      = r_h[5];
    assign bus.H6      = r_h[6];
    assign bus.H7      = r_h[7];
    assign bus.H8      = r_h[8];

endmodule

// File: tb/tb_fir_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_fir_stim_gen
//
// Purpose:
//   Directed bench for fir_stim_gen. It covers the coefficient writes, stream
//   latency and sequence, run length, drain timing, gaps, HOLD stalls and a
//   reset during a run. The expected LFSR values are written out by hand.
// -----------------------------------------------------------------------------
module tb_fir_stim_gen;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;

    always #5 CLK = ~CLK;

    fir_stim_gen_if #(.NB(11)) bus ();

    fir_stim_gen #(
        .NB           (11),
        .N_SAMPLES    (16),
        .SEED         (11'h001),
        .GAP_PERIOD   (4),
        .DRAIN_CYCLES (10)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    int nTests = 0;
    int nFail  = 0;
    int idx;

    // First 16 values of x^11+x^9+1 from seed 1, hand-stepped.
    logic [10:0] expSeq [16] = '{
        11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h080,
        11'h100, 11'h201, 11'h402, 11'h005, 11'h00A, 11'h014, 11'h028, 11'h050
    };

    logic [10:0] hv [9];
    assign hv[0] = bus.H0;
    assign hv[1] = bus.H1;
    assign hv[2] = bus.H2;
    assign hv[3] = bus.H3;
    assign hv[4] = bus.H4;
    assign hv[5] = bus.H5;
    assign hv[6] = bus.H6;
    assign hv[7] = bus.H7;
    assign hv[8] = bus.H8;

    // Advance one rising edge, then step 1 time unit past it. Driving and
    // sampling both happen here.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic gapEn,
                                 input logic hold, input logic hWe,
                                 input logic [3:0] hAddr,
                                 input logic [10:0] hData);
        bus.START  = start;
        bus.GAP_EN = gapEn;
        bus.HOLD   = hold;
        bus.H_WE   = hWe;
        bus.H_ADDR = hAddr;
        bus.H_DATA = hData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        RST_n = 1'b0;
        tick;
        tick;
        checkOutput("rst_vout", 32'(bus.VOUT), 32'd0);
        checkOutput("rst_end", 32'(bus.END_SIM), 32'd0);
        checkOutput("rst_dout", 32'($unsigned(bus.DOUT)), 32'd0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("rst_h%0d", i), 32'(hv[i]), 32'd0);
        end
        RST_n = 1'b1;

        // Coefficient writes, then an out-of-range address
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 11'(i + 1));
            tick;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 11'h7FF);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("wr_h%0d", i), 32'(hv[i]), 32'(i + 1));
        end

        // Run with no stalls: latency, sequence, count, drain, done
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        checkOutput("lat_vout_early", 32'(bus.VOUT), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick;
            checkOutput($sformatf("run_vout%0d", i), 32'(bus.VOUT), 32'd1);
            checkOutput($sformatf("run_dout%0d", i),
                        32'($unsigned(bus.DOUT)), 32'(expSeq[i]));
        end
        for (int d = 1; d < 10; d++) begin
            tick;
            checkOutput($sformatf("drain_vout%0d", d), 32'(bus.VOUT), 32'd0);
            checkOutput($sformatf("drain_end%0d", d), 32'(bus.END_SIM), 32'd0);
            checkOutput($sformatf("drain_dout%0d", d),
                        32'($unsigned(bus.DOUT)), 32'h050);
        end
        tick;
        checkOutput("done_end", 32'(bus.END_SIM), 32'd1);
        checkOutput("done_vout", 32'(bus.VOUT), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        tick;
        checkOutput("done_start_vout", 32'(bus.VOUT), 32'd0);
        checkOutput("done_start_end", 32'(bus.END_SIM), 32'd1);
        checkOutput("done_h4_kept", 32'(hv[4]), 32'd5);

        // Gap mode: 1,1,1,0 pattern, 16 samples over 21 RUN cycles
        RST_n = 1'b0;
        tick;
        RST_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 11'd0);
        idx = 0;
        for (int j = 0; j < 21; j++) begin
            tick;
            if ((j % 4) == 3) begin
                checkOutput($sformatf("gap_vout%0d", j), 32'(bus.VOUT), 32'd0);
                checkOutput($sformatf("gap_dout%0d", j),
                            32'($unsigned(bus.DOUT)), 32'(expSeq[idx - 1]));
            end else begin
                checkOutput($sformatf("gap_vout%0d", j), 32'(bus.VOUT), 32'd1);
                checkOutput($sformatf("gap_dout%0d", j),
                            32'($unsigned(bus.DOUT)), 32'(expSeq[idx]));
                idx++;
            end
        end
        tick;
        checkOutput("gap_after_vout", 32'(bus.VOUT), 32'd0);
        checkOutput("gap_after_dout", 32'($unsigned(bus.DOUT)), 32'h050);

        // HOLD for three cycles after four samples
        RST_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        RST_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 11'h155);
        tick;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput($sformatf("hold_pre_dout%0d", i),
                        32'($unsigned(bus.DOUT)), 32'(expSeq[i]));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 11'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput($sformatf("hold_vout%0d", i), 32'(bus.VOUT), 32'd0);
            checkOutput($sformatf("hold_dout%0d", i),
                        32'($unsigned(bus.DOUT)), 32'(expSeq[3]));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        checkOutput("hold_resume_vout", 32'(bus.VOUT), 32'd1);
        checkOutput("hold_resume_dout", 32'($unsigned(bus.DOUT)), 32'(expSeq[4]));
        checkOutput("hold_h3", 32'(hv[3]), 32'h155);

        // Reset mid-run after five samples, then restart from the seed
        RST_n = 1'b0;
        tick;
        checkOutput("mrst_vout", 32'(bus.VOUT), 32'd0);
        checkOutput("mrst_end", 32'(bus.END_SIM), 32'd0);
        checkOutput("mrst_dout", 32'($unsigned(bus.DOUT)), 32'd0);
        checkOutput("mrst_h3", 32'(hv[3]), 32'd0);
        RST_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 11'd0);
        tick;
        checkOutput("restart_vout", 32'(bus.VOUT), 32'd1);
        checkOutput("restart_dout0", 32'($unsigned(bus.DOUT)), 32'(expSeq[0]));
        tick;
        checkOutput("restart_dout1", 32'($unsigned(bus.DOUT)), 32'(expSeq[1]));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
